// File: rtl/dmem_port_arbiter.sv
// Shares one byte-write BRAM port between core word accesses and line bursts.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; default is line-first priority.
module dmem_port_arbiter #(
   parameter int ADDR_WIDTH = 11,
   parameter int NUM_COL    = 4,
   parameter int COL_WIDTH  = 8,
   parameter int DATA_WIDTH = NUM_COL*COL_WIDTH,
   parameter int BURST_LEN  = 4
) (
   input  logic                  clk,
   input  logic                  nrst,
   input  logic                  core_req,
   input  logic [NUM_COL-1:0]    core_we,
   input  logic [ADDR_WIDTH-1:0] core_addr,
   input  logic [DATA_WIDTH-1:0] core_wdata,
   output logic                  core_gnt,
   output logic                  core_rvalid,
   output logic [DATA_WIDTH-1:0] core_rdata,
   input  logic                  line_req,
   input  logic                  line_wr,
   input  logic [ADDR_WIDTH-1:0] line_addr,
   input  logic [DATA_WIDTH-1:0] line_wdata,
   output logic                  line_gnt,
   output logic                  line_wready,
   output logic                  line_rvalid,
   output logic [DATA_WIDTH-1:0] line_rdata,
   output logic                  line_done,
   output logic                  ram_en,
   output logic [NUM_COL-1:0]    ram_we,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic [DATA_WIDTH-1:0] ram_din,
   input  logic [DATA_WIDTH-1:0] ram_dout
);

   localparam int BW = $clog2(BURST_LEN);
   localparam int HW = ADDR_WIDTH - BW;
   localparam logic [BW-1:0] CNT_LAST = '1;

   typedef enum logic {IDLE, BURST} state_t;
   typedef enum logic [1:0] {TAG_NONE, TAG_CORE, TAG_LINE} tag_t;

   state_t                state_q, state_d;
   tag_t                  tag_q, tag_d;
   logic [BW-1:0]         cnt_q, cnt_d;
   logic [HW-1:0]         base_q, base_d;
   logic                  wr_q, wr_d;
   logic                  done_q, done_d;
   logic                  prio_q, prio_d;
   logic [DATA_WIDTH-1:0] core_rdata_q, core_rdata_d;
   logic [DATA_WIDTH-1:0] line_rdata_q, line_rdata_d;
   logic                  pick_line, pick_core;

   always_comb begin
      state_d     = state_q;
      tag_d       = TAG_NONE;
      cnt_d       = cnt_q;
      base_d      = base_q;
      wr_d        = wr_q;
      done_d      = 1'b0;
      prio_d      = prio_q;
      pick_line   = 1'b0;
      pick_core   = 1'b0;
      core_gnt    = 1'b0;
      line_gnt    = 1'b0;
      line_wready = 1'b0;
      line_done   = done_q;
      ram_en      = 1'b0;
      ram_we      = '0;
      ram_addr    = '0;
      ram_din     = '0;
      // Everything combinational is forced quiet while reset is held.
      if (nrst) begin
         unique case (state_q)
            IDLE: begin
`ifdef ARB_ROUND_ROBIN_EN
               pick_line = line_req && (!core_req || !prio_q);
`else
               pick_line = line_req;
`endif
               pick_core = core_req && !pick_line;
               if (pick_line) begin
                  line_gnt = 1'b1;
                  ram_en   = 1'b1;
                  ram_addr = {line_addr[ADDR_WIDTH-1:BW], {BW{1'b0}}};
                  base_d   = line_addr[ADDR_WIDTH-1:BW];
                  wr_d     = line_wr;
                  cnt_d    = BW'(1);
                  prio_d   = 1'b1;
                  state_d  = BURST;
                  if (line_wr) begin
                     ram_we      = '1;
                     ram_din     = line_wdata;
                     line_wready = 1'b1;
                  end else begin
                     tag_d = TAG_LINE;
                  end
               end else if (pick_core) begin
                  core_gnt = 1'b1;
                  ram_en   = 1'b1;
                  ram_we   = core_we;
                  ram_addr = core_addr;
                  ram_din  = core_wdata;
                  prio_d   = 1'b0;
                  if (core_we == '0) tag_d = TAG_CORE;
               end
            end
            BURST: begin
               ram_en   = 1'b1;
               ram_addr = {base_q, cnt_q};
               cnt_d    = cnt_q + BW'(1);
               if (wr_q) begin
                  ram_we      = '1;
                  ram_din     = line_wdata;
                  line_wready = 1'b1;
               end else begin
                  tag_d = TAG_LINE;
               end
               if (cnt_q == CNT_LAST) begin
                  state_d = IDLE;
                  cnt_d   = '0;
                  done_d  = !wr_q;
                  if (wr_q) line_done = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign core_rvalid  = (tag_q == TAG_CORE);
   assign line_rvalid  = (tag_q == TAG_LINE);
   assign core_rdata   = core_rvalid ? ram_dout : core_rdata_q;
   assign line_rdata   = line_rvalid ? ram_dout : line_rdata_q;
   assign core_rdata_d = core_rdata;
   assign line_rdata_d = line_rdata;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q      <= IDLE;
         tag_q        <= TAG_NONE;
         cnt_q        <= '0;
         base_q       <= '0;
         wr_q         <= 1'b0;
         done_q       <= 1'b0;
         prio_q       <= 1'b0;
         core_rdata_q <= '0;
         line_rdata_q <= '0;
      end else begin
         state_q      <= state_d;
         tag_q        <= tag_d;
         cnt_q        <= cnt_d;
         base_q       <= base_d;
         wr_q         <= wr_d;
         done_q       <= done_d;
         prio_q       <= prio_d;
         core_rdata_q <= core_rdata_d;
         line_rdata_q <= line_rdata_d;
      end
   end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Arbiter and sequencer for one port of the byte-write data BRAM. It shares the port between two requesters: the core load/store unit, which issues single-word accesses, and the data-cache line engine, which issues fixed-length refill and writeback bursts. It owns the port's enable, byte-write-enable, address and write-data signals, and routes the registered read data back to whichever requester issued the read.

## Interface
- ADDR_WIDTH, 11: word-address width of the BRAM.
- NUM_COL, 4: byte lanes per word.
- COL_WIDTH, 8: bits per lane.
- DATA_WIDTH, NUM_COL*COL_WIDTH: word width.
- BURST_LEN, 4: words per line burst. Power of two, at least 2.

Ports:
- clk  in  1  rising-edge clock.
- nrst  in  1  asynchronous active-low reset.
- core_req  in  1  core access request. Held with addr/we/wdata until granted.
- core_we  in  NUM_COL  byte write enables. All zero means a read.
- core_addr  in  ADDR_WIDTH  word address.
- core_wdata  in  DATA_WIDTH  write data.
- core_gnt  out  1  combinational. The access issues to the RAM this cycle.
- core_rvalid  out  1  core read data valid.
- core_rdata  out  DATA_WIDTH  core read data.
- line_req  in  1  burst request. Held until line_gnt.
- line_wr  in  1  1 = writeback burst (all lanes written), 0 = refill read.
- line_addr  in  ADDR_WIDTH  line base address. The low log2(BURST_LEN) bits are ignored and forced to 0.
- line_wdata  in  DATA_WIDTH  current writeback beat.
- line_gnt  out  1  combinational. Beat 0 issues this cycle.
- line_wready  out  1  combinational. The beat on line_wdata is consumed this cycle.
- line_rvalid  out  1  refill beat valid.
- line_rdata  out  DATA_WIDTH  refill beat data.
- line_done  out  1  one-cycle pulse marking the final beat.
- ram_en  out  1  port enable.
- ram_we  out  NUM_COL  port byte write enables.
- ram_addr  out  ADDR_WIDTH  port address.
- ram_din  out  DATA_WIDTH  port write data.
- ram_dout  in  DATA_WIDTH  port read data. Registered, 1-cycle latency, read-first.

## Operation
- FSM states: IDLE and BURST.
- IDLE
  - Core alone requesting: grant the core. Drive ram_en=1, ram_we=core_we, ram_addr=core_addr, ram_din=core_wdata. Stay in IDLE, so the core can be granted every cycle.
  - Line alone requesting: grant the line and issue beat 0 at the aligned base. Load the beat counter with 1 and go to BURST.
  - Both requesting: arbitration rule is given under Configuration.
  - Neither requesting: ram_en=0 and ram_we=0.
- BURST
  - Issue beat k at address base|k. For writes, ram_we is all ones and line_wready=1 on every beat.
  - Leave BURST after beat BURST_LEN-1 issues. The core is never granted during BURST, and a burst cannot be preempted.
- Read-return tag
  - A register records the owner of each issued read: none, core, or line.
  - The cycle after issue, raise the matching rvalid and route ram_dout to that requester's rdata. The other requester's rdata holds its last value.
  - Write beats produce no rvalid.
- line_done
  - Writeback: pulses in the same cycle as the last write beat.
  - Refill: pulses with the last line_rvalid.
- Return-cycle overlap: a core access may be granted in the cycle the last refill beat returns, because the port is free in that cycle.

## Timing
- Reset values: all outputs 0, FSM in IDLE, tag = none, beat counter 0, priority flag = line.
- Core read: gnt in cycle N, core_rvalid and core_rdata in N+1.
- Core write: gnt in cycle N, RAM updated at the end of cycle N.
- Burst: occupies cycles N to N+BURST_LEN-1. Refill rvalids fall in N+1 to N+BURST_LEN.
- Back-to-back bursts: the next line_gnt is possible no earlier than N+BURST_LEN.
- Beat address wraps within the aligned line and never carries into upper address bits.
- Reset asserted mid-burst: the FSM returns to IDLE immediately. No further rvalid or done is produced, and RAM contents already written remain.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on a simultaneous request, grant the requester not granted last.
  - The priority flag updates on every grant.
  - A burst counts as one grant.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, line wins every tie. Refill is never starved; the core waits out the burst.

## Test plan
- Core write then read: write core_we=4'b0011, addr 0x10, wdata 0xAABBCCDD over a word holding 0x11223344. The next core read of 0x10 returns 0x1122CCDD one cycle after gnt.
- Refill burst: line_addr 0x23 with words 0x20..0x23 preloaded to 0xA0..0xA3.
  - ram_addr sequence is 0x20,0x21,0x22,0x23.
  - line_rdata sequence is 0xA0..0xA3 on consecutive cycles, with line_done on the last.
- Writeback: line_addr 0x40 with data 1,2,3,4.
  - Four consecutive wready cycles, each with ram_we=4'b1111.
  - done on beat 3.
  - A readback of 0x40..0x43 returns 1..4.
- Contention: core_req and line_req both asserted from reset.
  - Without the macro: line granted, then the core at cycle 4.
  - With the macro: line, then core, then line alternate on repeated ties.
- Core blocked during burst: core_req asserted one cycle after line_gnt.
  - core_gnt stays 0 for 3 cycles, then asserts on the cycle the last refill beat returns.
  - core_rdata is correct.
- Reset abort: deassert nrst after beat 1 of a refill.
  - All outputs 0 immediately.
  - No line_done is produced.
  - After reset release, the arbiter accepts a new core request.
